// File: rtl/alu_ctl_pkg.sv
// Shared constants and the decoded control bundle for the ALU control stage.
// Optional variable-shift decode is enabled by defining ALU_CTL_VAR_SHIFT_EN.
package alu_ctl_pkg;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_SLT = 5'b00111;
   localparam logic [4:0] ALU_NOR = 5'b01100;
   localparam logic [4:0] ALU_XOR = 5'b01101;
   localparam logic [4:0] ALU_SLL = 5'b10000;
   localparam logic [4:0] ALU_SRL = 5'b11000;
   localparam logic [4:0] ALU_SRA = 5'b11001;

   localparam logic [1:0] IN1_RS      = 2'd0;
   localparam logic [1:0] IN1_SHAMT   = 2'd1;
   localparam logic [1:0] IN1_CONST16 = 2'd2;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_SRL  = 6'h02;
   localparam logic [5:0] FN_SRA  = 6'h03;
   localparam logic [5:0] FN_SLLV = 6'h04;
   localparam logic [5:0] FN_SRLV = 6'h06;
   localparam logic [5:0] FN_SRAV = 6'h07;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADD  = 6'h20;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB  = 6'h22;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_XOR  = 6'h26;
   localparam logic [5:0] FN_NOR  = 6'h27;
   localparam logic [5:0] FN_SLT  = 6'h2A;
   localparam logic [5:0] FN_SLTU = 6'h2B;

   typedef struct packed {
      logic [4:0] alu_ctl;
      logic       sign;
      logic [1:0] in1_sel;
      logic       in2_sel;
      logic       ext_signed;
      logic       illegal;
   } ctl_t;

endpackage

// File: rtl/alu_ctl_decode.sv
// Combinational MIPS instruction -> ALU control decode.
// ALU_CTL_VAR_SHIFT_EN adds sllv/srlv/srav (rs supplies the shift amount).
module alu_ctl_decode
   import alu_ctl_pkg::*;
(
   input  logic [31:0] inst,
   output ctl_t        ctl
);

   logic [5:0] op;
   logic [5:0] funct;

   assign op    = inst[31:26];
   assign funct = inst[5:0];

   always_comb begin
      ctl = '0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_ADDU, FN_JR: ctl.alu_ctl = ALU_ADD;
               FN_SUB, FN_SUBU:        ctl.alu_ctl = ALU_SUB;
               FN_AND:                 ctl.alu_ctl = ALU_AND;
               FN_OR:                  ctl.alu_ctl = ALU_OR;
               FN_XOR:                 ctl.alu_ctl = ALU_XOR;
               FN_NOR:                 ctl.alu_ctl = ALU_NOR;
               FN_SLT: begin
                  ctl.alu_ctl = ALU_SLT;
                  ctl.sign    = 1'b1;
               end
               FN_SLTU:                ctl.alu_ctl = ALU_SLT;
               FN_SLL: begin
                  ctl.alu_ctl = ALU_SLL;
                  ctl.in1_sel = IN1_SHAMT;
               end
               FN_SRL: begin
                  ctl.alu_ctl = ALU_SRL;
                  ctl.in1_sel = IN1_SHAMT;
               end
               FN_SRA: begin
                  ctl.alu_ctl = ALU_SRA;
                  ctl.in1_sel = IN1_SHAMT;
               end
`ifdef ALU_CTL_VAR_SHIFT_EN
               FN_SLLV:                ctl.alu_ctl = ALU_SLL;
               FN_SRLV:                ctl.alu_ctl = ALU_SRL;
               FN_SRAV:                ctl.alu_ctl = ALU_SRA;
`endif
               default:                ctl.illegal = 1'b1;
            endcase
         end
         OP_ADDI, OP_ADDIU, OP_LW, OP_SW: begin
            ctl.alu_ctl    = ALU_ADD;
            ctl.in2_sel    = 1'b1;
            ctl.ext_signed = 1'b1;
         end
         OP_ANDI: begin
            ctl.alu_ctl = ALU_AND;
            ctl.in2_sel = 1'b1;
         end
         OP_ORI: begin
            ctl.alu_ctl = ALU_OR;
            ctl.in2_sel = 1'b1;
         end
         OP_XORI: begin
            ctl.alu_ctl = ALU_XOR;
            ctl.in2_sel = 1'b1;
         end
         OP_SLTI: begin
            ctl.alu_ctl    = ALU_SLT;
            ctl.sign       = 1'b1;
            ctl.in2_sel    = 1'b1;
            ctl.ext_signed = 1'b1;
         end
         OP_SLTIU: begin
            ctl.alu_ctl    = ALU_SLT;
            ctl.in2_sel    = 1'b1;
            ctl.ext_signed = 1'b1;
         end
         OP_LUI: begin
            ctl.alu_ctl = ALU_SLL;
            ctl.in1_sel = IN1_CONST16;
            ctl.in2_sel = 1'b1;
         end
         OP_BEQ, OP_BNE:           ctl.alu_ctl = ALU_SUB;
         default:                  ctl.illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_ctl_stage.sv
// ALU control pipeline stage: decode on input, 2-entry skid buffer to EX.
// Decode options (ALU_CTL_VAR_SHIFT_EN) live in alu_ctl_decode.
module alu_ctl_stage
   import alu_ctl_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_inst,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_alu_ctl,
   output logic        out_sign,
   output logic [1:0]  out_in1_sel,
   output logic        out_in2_sel,
   output logic        out_ext_signed,
   output logic        out_illegal
);

   ctl_t dec;
   ctl_t main_q;
   ctl_t skid_q;
   logic main_v;
   logic skid_v;
   logic rdy_q;
   logic consume;
   logic accept;

   alu_ctl_decode u_decode (
      .inst (in_inst),
      .ctl  (dec)
   );

   assign consume = main_v & out_ready;
   assign accept  = in_valid & rdy_q;

   // rdy_q tracks "skid empty"; accept never coincides with an occupied skid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         main_q <= '0;
         skid_q <= '0;
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         rdy_q  <= 1'b1;
      end else if (!main_v || consume) begin
         if (skid_v) begin
            main_q <= skid_q;
            main_v <= 1'b1;
            skid_v <= 1'b0;
            rdy_q  <= 1'b1;
         end else if (accept) begin
            main_q <= dec;
            main_v <= 1'b1;
         end else begin
            main_v <= 1'b0;
         end
      end else if (accept) begin
         skid_q <= dec;
         skid_v <= 1'b1;
         rdy_q  <= 1'b0;
      end
   end

   assign in_ready       = rdy_q;
   assign out_valid      = main_v;
   assign out_alu_ctl    = main_q.alu_ctl;
   assign out_sign       = main_q.sign;
   assign out_in1_sel    = main_q.in1_sel;
   assign out_in2_sel    = main_q.in2_sel;
   assign out_ext_signed = main_q.ext_signed;
   assign out_illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_ctl_stage.sv
// Scoreboard bench for alu_ctl_stage: table-driven reference decode plus an
// in-order queue model of the stage occupancy (ALU_CTL_VAR_SHIFT_EN aware).
module tb_alu_ctl_stage;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_inst = '0;
   logic        flush = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [4:0]  out_alu_ctl;
   logic        out_sign;
   logic [1:0]  out_in1_sel;
   logic        out_in2_sel;
   logic        out_ext_signed;
   logic        out_illegal;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned acc_cnt = 0;
   logic        chk_en  = 1'b0;

   // expected word layout: {alu[4:0], sign, in1[1:0], in2, ext, illegal}
   logic [10:0] exp_q[$];
   logic [10:0] r_tab[logic [5:0]];
   logic [10:0] i_tab[logic [5:0]];
   localparam logic [10:0] ILL = 11'b1;

   logic [5:0] r_list [20] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08, 6'h20,
                               6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                               6'h2B, 6'h01, 6'h09, 6'h3F};
   logic [5:0] i_list [16] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                               6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h02, 6'h10, 6'h20, 6'h3F};

   alu_ctl_stage dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_inst        (in_inst),
      .flush          (flush),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_alu_ctl    (out_alu_ctl),
      .out_sign       (out_sign),
      .out_in1_sel    (out_in1_sel),
      .out_in2_sel    (out_in2_sel),
      .out_ext_signed (out_ext_signed),
      .out_illegal    (out_illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] mk(input logic [4:0] alu, input logic sgn,
                                      input logic [1:0] i1, input logic i2, input logic ext);
      return {alu, sgn, i1, i2, ext, 1'b0};
   endfunction

   function automatic logic [10:0] ref_decode(input logic [31:0] w);
      if (w[31:26] == 6'h00)
         return r_tab.exists(w[5:0]) ? r_tab[w[5:0]] : ILL;
      return i_tab.exists(w[31:26]) ? i_tab[w[31:26]] : ILL;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [10:0] dut_word();
      return {out_alu_ctl, out_sign, out_in1_sel, out_in2_sel, out_ext_signed, out_illegal};
   endfunction

   // stimulus side: log every accepted instruction's expected decode
   always @(posedge clk) begin
      if (reset_n && in_valid && in_ready && !flush) begin
         exp_q.push_back(ref_decode(in_inst));
         acc_cnt++;
      end
   end

   // monitor: consume outputs against the scoreboard
   always @(posedge clk) begin
      if (reset_n && chk_en) begin
         if (flush) begin
            exp_q.delete();
         end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 32'(dut_word()), 32'hDEAD);
            end else begin
               check("payload", 32'(dut_word()), 32'(exp_q[0]));
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // monitor: handshake state must match the queue occupancy
   always @(negedge clk) begin
      if (reset_n && chk_en) begin
         check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
         check("in_ready", 32'(in_ready), 32'(exp_q.size() < 2));
      end
   end

   task automatic cyc(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
      in_valid  = iv;
      in_inst   = w;
      out_ready = ordy;
      flush     = fl;
      @(negedge clk);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(3))
         0: begin w[31:26] = 6'h00; w[5:0] = r_list[$urandom_range(19)]; end
         1: w[31:26] = i_list[$urandom_range(15)];
         2: w[31:26] = 6'h00;
         default: ;
      endcase
      return w;
   endfunction

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) cyc(1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      int unsigned base;
      r_tab[6'h20] = mk(5'b00010, 0, 2'd0, 0, 0);
      r_tab[6'h21] = mk(5'b00010, 0, 2'd0, 0, 0);
      r_tab[6'h08] = mk(5'b00010, 0, 2'd0, 0, 0);
      r_tab[6'h22] = mk(5'b00110, 0, 2'd0, 0, 0);
      r_tab[6'h23] = mk(5'b00110, 0, 2'd0, 0, 0);
      r_tab[6'h24] = mk(5'b00000, 0, 2'd0, 0, 0);
      r_tab[6'h25] = mk(5'b00001, 0, 2'd0, 0, 0);
      r_tab[6'h26] = mk(5'b01101, 0, 2'd0, 0, 0);
      r_tab[6'h27] = mk(5'b01100, 0, 2'd0, 0, 0);
      r_tab[6'h2A] = mk(5'b00111, 1, 2'd0, 0, 0);
      r_tab[6'h2B] = mk(5'b00111, 0, 2'd0, 0, 0);
      r_tab[6'h00] = mk(5'b10000, 0, 2'd1, 0, 0);
      r_tab[6'h02] = mk(5'b11000, 0, 2'd1, 0, 0);
      r_tab[6'h03] = mk(5'b11001, 0, 2'd1, 0, 0);
`ifdef ALU_CTL_VAR_SHIFT_EN
      r_tab[6'h04] = mk(5'b10000, 0, 2'd0, 0, 0);
      r_tab[6'h06] = mk(5'b11000, 0, 2'd0, 0, 0);
      r_tab[6'h07] = mk(5'b11001, 0, 2'd0, 0, 0);
`endif
      i_tab[6'h08] = mk(5'b00010, 0, 2'd0, 1, 1);
      i_tab[6'h09] = mk(5'b00010, 0, 2'd0, 1, 1);
      i_tab[6'h23] = mk(5'b00010, 0, 2'd0, 1, 1);
      i_tab[6'h2B] = mk(5'b00010, 0, 2'd0, 1, 1);
      i_tab[6'h0C] = mk(5'b00000, 0, 2'd0, 1, 0);
      i_tab[6'h0D] = mk(5'b00001, 0, 2'd0, 1, 0);
      i_tab[6'h0E] = mk(5'b01101, 0, 2'd0, 1, 0);
      i_tab[6'h0A] = mk(5'b00111, 1, 2'd0, 1, 1);
      i_tab[6'h0B] = mk(5'b00111, 0, 2'd0, 1, 1);
      i_tab[6'h0F] = mk(5'b10000, 0, 2'd2, 1, 0);
      i_tab[6'h04] = mk(5'b00110, 0, 2'd0, 0, 0);
      i_tab[6'h05] = mk(5'b00110, 0, 2'd0, 0, 0);

      // reset state
      #12;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_payload", 32'(dut_word()), 0);
      @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // directed decodes, first acceptance right after reset release
      cyc(1'b1, 32'h00221820, 1'b1, 1'b0);
      check("add_latency", 32'(out_valid), 1);
      cyc(1'b1, 32'h2822FFFF, 1'b1, 1'b0);
      cyc(1'b1, 32'h3C011234, 1'b1, 1'b0);
      cyc(1'b1, 32'h00621004, 1'b1, 1'b0);
      idle(3);

      // three back-to-back offers into a stalled stage
      base = acc_cnt;
      cyc(1'b1, 32'h00221820, 1'b0, 1'b0);
      cyc(1'b1, 32'h00221822, 1'b0, 1'b0);
      cyc(1'b1, 32'h00221824, 1'b0, 1'b0);
      check("stall_accepted", acc_cnt - base, 2);
      check("stall_in_ready", 32'(in_ready), 0);
      for (int unsigned i = 0; i < 10 && (acc_cnt - base) < 3; i++)
         cyc(1'b1, 32'h00221824, 1'b1, 1'b0);
      check("stall_third_accepted", acc_cnt - base, 3);
      idle(4);

      // fill both entries, flush together with an offer
      cyc(1'b1, 32'h00221825, 1'b0, 1'b0);
      cyc(1'b1, 32'h00221826, 1'b0, 1'b0);
      cyc(1'b1, 32'h00221827, 1'b1, 1'b1);
      check("flush_out_valid", 32'(out_valid), 0);
      check("flush_in_ready", 32'(in_ready), 1);
      idle(4);

      // reset during a stall drops the held entries
      cyc(1'b1, 32'h00221820, 1'b0, 1'b0);
      cyc(1'b1, 32'h00221822, 1'b0, 1'b0);
      chk_en  = 1'b0;
      reset_n = 1'b0;
      #1;
      check("stall_rst_out_valid", 32'(out_valid), 0);
      check("stall_rst_in_ready", 32'(in_ready), 1);
      check("stall_rst_payload", 32'(dut_word()), 0);
      exp_q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      chk_en  = 1'b1;

      // randomized traffic
      for (int unsigned i = 0; i < 3000; i++)
         cyc($urandom_range(3) != 0, rand_inst(), $urandom_range(2) != 0,
             $urandom_range(39) == 0);
      idle(6);
      check("drain_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_ctl_stage.md
ALU_CTL_STAGE -- requirements
Module: alu_ctl_stage

Interface
- REQ-001 The block SHALL have no parameters; all widths are fixed.
- REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports listed first as `clk` (input, 1, rising-edge clock) and `reset_n` (input, 1, asynchronous active-low reset).
- REQ-003 `in_valid` (input, 1) SHALL indicate that an instruction is offered.
- REQ-004 `in_ready` (output, 1) SHALL indicate that the stage accepts an instruction; a transfer occurs on `in_valid & in_ready`.
- REQ-005 `in_inst` (input, 32) SHALL carry the MIPS instruction word.
- REQ-006 `flush` (input, 1) SHALL discard all held entries.
- REQ-007 `out_valid` (output, 1) SHALL indicate that a decoded entry is presented.
- REQ-008 `out_ready` (input, 1) SHALL indicate that the EX stage consumes the entry; a transfer occurs on `out_valid & out_ready`.
- REQ-009 `out_alu_ctl` (output, 5) SHALL carry the ALU operation code.
- REQ-010 `out_sign` (output, 1) SHALL select signed compare for SLT.
- REQ-011 `out_in1_sel` (output, 2) SHALL select ALU operand 1: 0 = rs, 1 = shamt, 2 = constant 16.
- REQ-012 `out_in2_sel` (output, 1) SHALL select ALU operand 2: 0 = rt, 1 = extended immediate.
- REQ-013 `out_ext_signed` (output, 1) SHALL select immediate extension: 1 = sign-extend, 0 = zero-extend.
- REQ-014 `out_illegal` (output, 1) SHALL flag an undecodable instruction.

Function
- REQ-015 ALU codes SHALL be:
  - AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111
  - NOR 01100, XOR 01101, SLL 10000, SRL 11000, SRA 11001
- REQ-016 R-type (op 0x00) decode SHALL be by funct:
  - 0x20/0x21 → ADD; 0x22/0x23 → SUB; 0x24 → AND; 0x25 → OR; 0x26 → XOR; 0x27 → NOR
  - 0x2A → SLT with sign=1; 0x2B → SLT with sign=0
  - 0x00/0x02/0x03 → SLL/SRL/SRA with in1_sel=1
  - 0x08 (jr) → ADD
- REQ-017 I-type decode SHALL set in2_sel=1 and be by opcode:
  - 0x08/0x09 → ADD, ext_signed=1; 0x23/0x2B → ADD, ext_signed=1
  - 0x0C/0x0D/0x0E → AND/OR/XOR, ext_signed=0
  - 0x0A → SLT, sign=1, ext_signed=1; 0x0B → SLT, sign=0, ext_signed=1
  - 0x0F (lui) → SLL, in1_sel=2, ext_signed=0
- REQ-018 Branches 0x04/0x05 SHALL decode as SUB with in2_sel=0.
- REQ-019 Any other opcode/funct SHALL set illegal=1 and all other fields to 0.
- REQ-020 `out_sign` SHALL be 0 for every non-SLT operation.
- REQ-021 Latency SHALL be 1 cycle: an instruction accepted at edge N SHALL be presented with `out_valid`=1 after edge N.
- REQ-022 Buffering SHALL be a 2-entry skid buffer (main + skid); `in_ready` SHALL be a registered signal equal to "skid empty".
- REQ-023 With `out_ready` held at 1, the block SHALL sustain one transfer per cycle with no bubbles.
- REQ-024 If main is valid and not consumed while an input is accepted, the input SHALL go to skid and `in_ready` SHALL drop the following cycle.
- REQ-025 When main is consumed, skid SHALL move to main and `in_ready` SHALL rise the following cycle.
- REQ-026 Entries SHALL leave in strict acceptance order; none is lost or duplicated.
- REQ-027 On `flush`=1 at an edge, both valid bits SHALL clear, any same-cycle input transfer SHALL be discarded, and `in_ready`=1 and `out_valid`=0 SHALL hold after that edge.
- REQ-028 Flush SHALL take priority over simultaneous acceptance and consumption.
- REQ-029 Payload outputs SHALL hold their last value while `out_valid`=0 and are don't-care.

Reset
- REQ-030 Asserting `reset_n`=0 SHALL immediately force `out_valid`=0, `in_ready`=1, all payload outputs to 0, and skid empty.
- REQ-031 Reset during a stall SHALL drop held entries without any output transfer.
- REQ-032 The first acceptance SHALL be possible at the first rising edge after `reset_n` deasserts.

Configuration
- REQ-033 Macro ALU_CTL_VAR_SHIFT_EN defined: funct 0x04/0x06/0x07 SHALL decode to SLL/SRL/SRA with in1_sel=0 (rs supplies the amount).
- REQ-034 Macro ALU_CTL_VAR_SHIFT_EN undefined: funct 0x04/0x06/0x07 SHALL decode as illegal per REQ-019.

Structure
- REQ-035 Package `alu_ctl_pkg` SHALL hold the ALU code constants, the in1_sel encodings, and the opcode/funct constants.
- REQ-036 Combinational decode SHALL live in sub-module `alu_ctl_decode`, instantiated once on `in_inst`; the skid buffer stays in `alu_ctl_stage`.

Verification
- REQ-037 Send 0x00221820 (add) with out_ready=1 → next cycle out_valid=1, alu_ctl=00010, in1_sel=0, in2_sel=0, illegal=0.
- REQ-038 Send 0x2822FFFF (slti) → alu_ctl=00111, sign=1, in2_sel=1, ext_signed=1.
- REQ-039 Send 0x3C011234 (lui) → alu_ctl=10000, in1_sel=2, in2_sel=1, ext_signed=0.
- REQ-040 Offer 3 back-to-back instructions with out_ready=0 → exactly 2 accepted and in_ready=0; then raise out_ready → outputs in order, third accepted, no loss or duplicate.
- REQ-041 Fill both entries, then assert flush together with in_valid=1 → out_valid=0 and in_ready=1 next cycle, and nothing emitted afterward.
- REQ-042 Send 0x00621004 (sllv) → with the macro: alu_ctl=10000, in1_sel=0, illegal=0; without the macro: illegal=1, alu_ctl=00000.
